// File: rtl/ddr_ins_arb.sv
// rtl/ddr_ins_arb.sv - N-channel DDR command arbiter with write-burst lock (option: DDR_ARB_FIXED_PRIO_EN)
module ddr_ins_arb #(
    parameter int NUM_CH    = 4,
    parameter int BANDWIDTH = 512,
    parameter int ADDR_W    = 26,
    parameter int BL_W      = 7,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_vld,
    output logic [NUM_CH-1:0]             ch_rdy,
    input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
    input  logic [NUM_CH*BANDWIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]             ch_rd_req,
    input  logic [NUM_CH-1:0]             ch_wr_req,
    input  logic [NUM_CH*BL_W-1:0]        ch_bl,
    output logic                          ddr_ins_op_vld,
    input  logic                          ddr_ins_op_rdy,
    output logic [ADDR_W-1:0]             ddr_address,
    output logic [BANDWIDTH-1:0]          ddr_write_data,
    output logic                          ddr_rd_req,
    output logic                          ddr_wr_req,
    output logic [BL_W-1:0]               ddr_bl_size,
    output logic [CH_W-1:0]               ddr_ins_ch
);

    typedef enum logic {ARB = 1'b0, WR_BURST = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        lock_q, lock_d;
    logic [BL_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]      haddr_q;
    logic [BL_W-1:0]        hbl_q;

    logic [CH_W-1:0]        start_idx;
    logic [CH_W-1:0]        gnt;
    logic                   gnt_found;
    logic [CH_W-1:0]        sel;
    logic                   sel_found;
    logic                   load_en;
    logic                   xfer;

    logic [ADDR_W-1:0]      sel_addr;
    logic [BANDWIDTH-1:0]   sel_data;
    logic [BL_W-1:0]        sel_bl;
    logic [BL_W-1:0]        sel_eff_bl;
    logic                   sel_rd;
    logic                   sel_wr_eff;
    logic                   burst_start;

    assign load_en = !ddr_ins_op_vld | ddr_ins_op_rdy;

`ifdef DDR_ARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_next;

    assign start_idx = ptr_q;
    assign ptr_next  = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);

    // Round-robin pointer moves past a channel once its transaction completes
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer && ((state_q == ARB) ? !burst_start : (cnt_q == BL_W'(1)))) begin
            ptr_q <= ptr_next;
        end
    end
`endif

    // First requesting channel at or after the search start, with wrap
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(start_idx) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_found && ch_vld[idx]) begin
                gnt_found = 1'b1;
                gnt       = CH_W'(idx);
            end
        end
    end

    // A locked burst ignores everyone except the owning channel
    assign sel        = (state_q == WR_BURST) ? lock_q : gnt;
    assign sel_found  = (state_q == WR_BURST) ? ch_vld[lock_q] : gnt_found;
    assign sel_addr   = ch_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_data   = ch_data[int'(sel)*BANDWIDTH +: BANDWIDTH];
    assign sel_bl     = ch_bl[int'(sel)*BL_W +: BL_W];
    assign sel_eff_bl = (sel_bl == '0) ? BL_W'(1) : sel_bl;
    assign sel_rd     = ch_rd_req[sel];
    assign sel_wr_eff = ch_wr_req[sel] & ~sel_rd;
    assign burst_start = sel_wr_eff && (sel_eff_bl > BL_W'(1));
    assign xfer       = sel_found & load_en & !rst;

    // State register: arbitration state, lock owner and beats remaining
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            lock_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter a burst on a multi-beat write head, leave on its last beat
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (xfer && burst_start) begin
                    state_d = WR_BURST;
                    lock_d  = sel;
                    cnt_d   = sel_eff_bl - BL_W'(1);
                end
            end
            WR_BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q - BL_W'(1);
                    if (cnt_q == BL_W'(1)) state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Outputs: only the selected channel sees ready, and only when the output slot frees
    always_comb begin
        ch_rdy = '0;
        if (!rst && sel_found) ch_rdy[sel] = load_en;
    end

    // Output register and burst head capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ddr_ins_op_vld <= 1'b0;
            ddr_address    <= '0;
            ddr_write_data <= '0;
            ddr_rd_req     <= 1'b0;
            ddr_wr_req     <= 1'b0;
            ddr_bl_size    <= '0;
            ddr_ins_ch     <= '0;
            haddr_q        <= '0;
            hbl_q          <= '0;
        end else begin
            if (load_en) begin
                if (xfer) begin
                    ddr_ins_op_vld <= 1'b1;
                    ddr_ins_ch     <= sel;
                    ddr_write_data <= sel_data;
                    if (state_q == ARB) begin
                        ddr_address <= sel_addr;
                        ddr_bl_size <= sel_bl;
                        ddr_rd_req  <= sel_rd;
                        ddr_wr_req  <= sel_wr_eff;
                    end else begin
                        ddr_address <= haddr_q;
                        ddr_bl_size <= hbl_q;
                        ddr_rd_req  <= 1'b0;
                        ddr_wr_req  <= 1'b1;
                    end
                end else begin
                    ddr_ins_op_vld <= 1'b0;
                end
            end
            if (state_q == ARB && xfer && burst_start) begin
                haddr_q <= sel_addr;
                hbl_q   <= sel_bl;
            end
        end
    end

endmodule

// File: tb/tb_ddr_ins_arb.sv
// tb/tb_ddr_ins_arb.sv - directed self-checking bench for ddr_ins_arb
module tb_ddr_ins_arb;

    localparam int NCH = 4;
    localparam int BW  = 512;
    localparam int AW  = 26;
    localparam int BLW = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       ch_vld;
    logic [NCH-1:0]       ch_rdy;
    logic [NCH*AW-1:0]    ch_addr;
    logic [NCH*BW-1:0]    ch_data;
    logic [NCH-1:0]       ch_rd_req;
    logic [NCH-1:0]       ch_wr_req;
    logic [NCH*BLW-1:0]   ch_bl;
    logic                 ddr_ins_op_vld;
    logic                 ddr_ins_op_rdy;
    logic [AW-1:0]        ddr_address;
    logic [BW-1:0]        ddr_write_data;
    logic                 ddr_rd_req;
    logic                 ddr_wr_req;
    logic [BLW-1:0]       ddr_bl_size;
    logic [1:0]           ddr_ins_ch;

    int checks = 0;
    int errors = 0;
    int acc    = 0;

    ddr_ins_arb #(.NUM_CH(NCH), .BANDWIDTH(BW), .ADDR_W(AW), .BL_W(BLW)) dut (
        .clk(clk), .rst(rst),
        .ch_vld(ch_vld), .ch_rdy(ch_rdy), .ch_addr(ch_addr), .ch_data(ch_data),
        .ch_rd_req(ch_rd_req), .ch_wr_req(ch_wr_req), .ch_bl(ch_bl),
        .ddr_ins_op_vld(ddr_ins_op_vld), .ddr_ins_op_rdy(ddr_ins_op_rdy),
        .ddr_address(ddr_address), .ddr_write_data(ddr_write_data),
        .ddr_rd_req(ddr_rd_req), .ddr_wr_req(ddr_wr_req),
        .ddr_bl_size(ddr_bl_size), .ddr_ins_ch(ddr_ins_ch)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] dat(input int k);
        logic [31:0] w;
        w = 32'hDA7A_0000 | k;
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic v, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [BLW-1:0] bl);
        ch_vld[i]             = v;
        ch_rd_req[i]          = rd;
        ch_wr_req[i]          = wr;
        ch_addr[i*AW +: AW]   = a;
        ch_data[i*BW +: BW]   = d;
        ch_bl[i*BLW +: BLW]   = bl;
    endtask

    task automatic tick();
        if (ddr_ins_op_vld && ddr_ins_op_rdy) acc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ch_vld = '0;
        tick();
        rst    = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input int ch, input logic [AW-1:0] a,
                           input logic rd, input logic wr, input logic [BLW-1:0] bl);
        chk({tag, "_vld"}, ddr_ins_op_vld, v);
        chk({tag, "_ch"}, ddr_ins_ch, ch);
        chk({tag, "_addr"}, ddr_address, a);
        chk({tag, "_rd"}, ddr_rd_req, rd);
        chk({tag, "_wr"}, ddr_wr_req, wr);
        chk({tag, "_bl"}, ddr_bl_size, bl);
    endtask

    initial begin
        int exp_ch;
        rst            = 1'b1;
        ddr_ins_op_rdy = 1'b1;
        ch_vld = '0; ch_rd_req = '0; ch_wr_req = '0;
        ch_addr = '0; ch_data = '0; ch_bl = '0;
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b1, 1'b0, AW'(32'h100 + i), dat(i), 7'd1);

        // reset: requests present but nothing granted or emitted
        #1;
        chk("rst_rdy", ch_rdy, 4'b0000);
        tick();
        chk("rst_rdy2", ch_rdy, 4'b0000);
        chk_out("rst", 1'b0, 0, '0, 1'b0, 1'b0, '0);
        chk("rst_data", ddr_write_data, '0);
        rst    = 1'b0;
        ch_vld = '0;

        // ch0 and ch2 single reads
        set_ch(0, 1'b1, 1'b1, 1'b0, 26'h0A0, dat(10), 7'd2);
        set_ch(2, 1'b1, 1'b1, 1'b0, 26'h0A2, dat(12), 7'd3);
        #1;
        chk("t1_rdy0", ch_rdy, 4'b0001);
        tick();
        chk_out("t1_b0", 1'b1, 0, 26'h0A0, 1'b1, 1'b0, 7'd2);
        ch_vld[0] = 1'b0;
        #1;
        chk("t1_rdy1", ch_rdy, 4'b0100);
        tick();
        chk_out("t1_b1", 1'b1, 2, 26'h0A2, 1'b1, 1'b0, 7'd3);
        ch_vld[2] = 1'b0;
        tick();
        chk("t1_idle_vld", ddr_ins_op_vld, 1'b0);
        chk("t1_hold_addr", ddr_address, 26'h0A2);

        // all channels reading continuously
        do_reset();
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b1, 1'b0, AW'(32'h100 + i), dat(i), 7'd1);
        for (int k = 0; k < 6; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = k % NCH;
`endif
            #1;
            chk($sformatf("t2_rdy%0d", k), ch_rdy, 4'b0001 << exp_ch);
            tick();
            chk($sformatf("t2_ch%0d", k), ddr_ins_ch, exp_ch);
            chk($sformatf("t2_addr%0d", k), ddr_address, AW'(32'h100 + exp_ch));
        end
        ch_vld = '0;

        // ch1 write burst bl=4 while ch3 waits
        do_reset();
        set_ch(3, 1'b1, 1'b1, 1'b0, 26'h3333, dat(33), 7'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) set_ch(1, 1'b1, 1'b0, 1'b1, 26'h2000, dat(20), 7'd4);
            else        set_ch(1, 1'b1, 1'b1, 1'b0, AW'(32'h2F00 + k), dat(20 + k), 7'd9);
            #1;
            chk($sformatf("t3_rdy%0d", k), ch_rdy, 4'b0010);
            tick();
            chk_out($sformatf("t3_b%0d", k), 1'b1, 1, 26'h2000, 1'b0, 1'b1, 7'd4);
            chk($sformatf("t3_data%0d", k), ddr_write_data, dat(20 + k));
        end
        ch_vld[1] = 1'b0;
        #1;
        chk("t3_rdy_ch3", ch_rdy, 4'b1000);
        tick();
        chk_out("t3_ch3", 1'b1, 3, 26'h3333, 1'b1, 1'b0, 7'd1);
        ch_vld = '0;

        // ch1 write bl=3 under backpressure 1,0,0,1,1
        do_reset();
        acc = 0;
        set_ch(1, 1'b1, 1'b0, 1'b1, 26'h4100, dat(40), 7'd3);
        ddr_ins_op_rdy = 1'b1;
        #1;
        chk("t4_rdy0", ch_rdy, 4'b0010);
        tick();
        chk("t4_d0", ddr_write_data, dat(40));
        set_ch(1, 1'b1, 1'b1, 1'b0, 26'h0, dat(41), 7'd0);
        for (int k = 0; k < 2; k++) begin
            ddr_ins_op_rdy = 1'b0;
            #1;
            chk($sformatf("t4_stall_rdy%0d", k), ch_rdy, 4'b0000);
            tick();
            chk_out($sformatf("t4_hold%0d", k), 1'b1, 1, 26'h4100, 1'b0, 1'b1, 7'd3);
            chk($sformatf("t4_hold_data%0d", k), ddr_write_data, dat(40));
        end
        ddr_ins_op_rdy = 1'b1;
        #1;
        chk("t4_rdy1", ch_rdy, 4'b0010);
        tick();
        chk("t4_d1", ddr_write_data, dat(41));
        set_ch(1, 1'b1, 1'b1, 1'b0, 26'h0, dat(42), 7'd0);
        #1;
        chk("t4_rdy2", ch_rdy, 4'b0010);
        tick();
        chk_out("t4_b2", 1'b1, 1, 26'h4100, 1'b0, 1'b1, 7'd3);
        chk("t4_d2", ddr_write_data, dat(42));
        ch_vld = '0;
        tick();
        tick();
        chk("t4_beats", acc, 3);
        chk("t4_idle", ddr_ins_op_vld, 1'b0);

        // reset abandons a bl=8 burst after two beats
        do_reset();
        set_ch(1, 1'b1, 1'b0, 1'b1, 26'h4000, dat(50), 7'd8);
        tick();
        set_ch(1, 1'b1, 1'b0, 1'b1, 26'h4000, dat(51), 7'd8);
        tick();
        chk("t5_b1", ddr_write_data, dat(51));
        rst = 1'b1;
        #1;
        chk("t5_rst_rdy", ch_rdy, 4'b0000);
        tick();
        rst = 1'b0;
        chk_out("t5_rst", 1'b0, 0, '0, 1'b0, 1'b0, '0);
        chk("t5_rst_data", ddr_write_data, '0);
        ch_vld[1] = 1'b0;
        set_ch(2, 1'b1, 1'b1, 1'b0, 26'h5555, dat(55), 7'd1);
        #1;
        chk("t5_rdy_ch2", ch_rdy, 4'b0100);
        tick();
        chk_out("t5_ch2", 1'b1, 2, 26'h5555, 1'b1, 1'b0, 7'd1);
        ch_vld = '0;

        // bl=0 write is a single beat; rd+wr resolves to read
        set_ch(0, 1'b1, 1'b0, 1'b1, 26'h6000, dat(60), 7'd0);
        #1;
        chk("t6_rdy_w", ch_rdy, 4'b0001);
        tick();
        chk_out("t6_w", 1'b1, 0, 26'h6000, 1'b0, 1'b1, 7'd0);
        ch_vld[0] = 1'b0;
        set_ch(3, 1'b1, 1'b1, 1'b0, 26'h6333, dat(63), 7'd1);
        #1;
        chk("t6_nolock", ch_rdy, 4'b1000);
        tick();
        chk_out("t6_ch3", 1'b1, 3, 26'h6333, 1'b1, 1'b0, 7'd1);
        ch_vld[3] = 1'b0;
        set_ch(0, 1'b1, 1'b1, 1'b1, 26'h7000, dat(70), 7'd5);
        #1;
        chk("t6_rdy_rw", ch_rdy, 4'b0001);
        tick();
        chk_out("t6_rw", 1'b1, 0, 26'h7000, 1'b1, 1'b0, 7'd5);
        ch_vld[0] = 1'b0;
        set_ch(2, 1'b1, 1'b1, 1'b0, 26'h7222, dat(72), 7'd1);
        #1;
        chk("t6_rdy_after_rw", ch_rdy, 4'b0100);
        tick();
        chk_out("t6_ch2", 1'b1, 2, 26'h7222, 1'b1, 1'b0, 7'd1);
        ch_vld = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
